// File: rtl/ps_conv_pkg.sv
// ps_conv_pkg: shared types, fixed kernels and width helpers
// for the 3x3 pixel-stream convolution engine.
package ps_conv_pkg;

  typedef enum logic [1:0] {
    MODE_GAUSS  = 2'd0,
    MODE_SHARP  = 2'd1,
    MODE_EDGE   = 2'd2,
    MODE_CUSTOM = 2'd3
  } mode_e;

  localparam int NTAP = 9;
  // Fixed taps need 5 signed bits: the Laplacian centre is +8.
  localparam int KW   = 5;

  // Packed tap8..tap0, tap index 3*row+col, tap 0 at the LSBs.
  localparam logic [NTAP*KW-1:0] K_GAUSS = {
    5'd1, 5'd2, 5'd1,
    5'd2, 5'd4, 5'd2,
    5'd1, 5'd2, 5'd1
  };
  localparam logic [NTAP*KW-1:0] K_SHARP = {
    5'd0,  5'h1f, 5'd0,
    5'h1f, 5'd5,  5'h1f,
    5'd0,  5'h1f, 5'd0
  };
  localparam logic [NTAP*KW-1:0] K_EDGE = {
    5'h1f, 5'h1f, 5'h1f,
    5'h1f, 5'd8,  5'h1f,
    5'h1f, 5'h1f, 5'h1f
  };

  localparam int S_GAUSS = 4;
  localparam int S_SHARP = 0;
  localparam int S_EDGE  = 0;

  // Internal coefficient width: wide enough for user and fixed taps.
  function automatic int coef_w(input int cw);
    return (cw > KW) ? cw : KW;
  endfunction

  // Nine products of DW+CIW+1 bits need 4 more bits to never overflow.
  function automatic int acc_w(input int dw, input int cw);
    return dw + coef_w(cw) + 5;
  endfunction

endpackage

// File: rtl/ps_conv_round_clamp.sv
// ps_conv_round_clamp: round-half-up, arithmetic right shift
// and clamp of a signed accumulator into an unsigned pixel.
module ps_conv_round_clamp #(
  parameter int ACCW = 19,
  parameter int DW   = 8,
  parameter int SW   = 4
) (
  input  logic signed [ACCW-1:0] i_acc,
  input  logic        [SW-1:0]   i_shift,
  output logic        [DW-1:0]   o_data
);

  localparam int AW1 = ACCW + 1;
  localparam logic signed [AW1-1:0] ONE  = AW1'(1);
  localparam logic signed [AW1-1:0] MAXV = AW1'((1 << DW) - 1);

  logic signed [AW1-1:0] w_rnd;
  logic signed [AW1-1:0] w_sum;
  logic signed [AW1-1:0] w_shr;

  // One guard bit keeps the rounding add from wrapping.
  always_comb begin
    w_rnd = '0;
    if (i_shift != '0) begin
      w_rnd = ONE << (i_shift - SW'(1));
    end
    w_sum  = AW1'(i_acc) + w_rnd;
    w_shr  = w_sum >>> i_shift;
    o_data = w_shr[DW-1:0];
    if (w_shr[AW1-1]) begin
      o_data = '0;
    end else if (w_shr > MAXV) begin
      o_data = MAXV[DW-1:0];
    end
  end

endmodule

// File: rtl/ps_conv3x3.sv
// ps_conv3x3: mode-selectable 3x3 convolution, rigid 3-stage
// pipeline (products, sum, round/clamp) with valid/ready.
module ps_conv3x3
  import ps_conv_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 6,
  parameter int SW = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [3*DW-1:0]      i_r0_data,
  input  logic [3*DW-1:0]      i_r1_data,
  input  logic [3*DW-1:0]      i_r2_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_mode,
  input  logic                 i_coef_we,
  input  logic [3:0]           i_coef_addr,
  input  logic signed [CW-1:0] i_coef_data,
  input  logic [SW-1:0]        i_cfg_shift,
  output logic [DW-1:0]        o_data,
  output logic                 o_valid,
  input  logic                 i_ready
);

  localparam int CIW  = coef_w(CW);
  localparam int PW   = DW + CIW + 1;
  localparam int ACCW = acc_w(DW, CW);
  localparam int SMAX = ACCW - 1;

  logic                   w_en;
  logic                   w_acc;
  logic [DW-1:0]          w_pix   [NTAP];
  logic signed [CIW-1:0]  w_coef  [NTAP];
  logic signed [PW-1:0]   w_prod  [NTAP];
  logic [SW-1:0]          w_cfg_shift;
  logic [SW-1:0]          w_shift;
  logic signed [ACCW-1:0] w_sum;
  logic [DW-1:0]          w_rc_data;

  logic signed [CIW-1:0]  r_cust  [NTAP];
  logic                   r_s1_valid;
  logic signed [PW-1:0]   r_s1_prod [NTAP];
  logic [SW-1:0]          r_s1_shift;
  logic                   r_s2_valid;
  logic signed [ACCW-1:0] r_s2_acc;
  logic [SW-1:0]          r_s2_shift;
  logic                   r_o_valid;
  logic [DW-1:0]          r_o_data;

  assign w_en    = !r_o_valid || i_ready;
  assign w_acc   = i_valid && w_en;
  assign o_ready = w_en;
  assign o_valid = r_o_valid;
  assign o_data  = r_o_data;

  // Unpack the window and saturate the user shift.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      w_pix[c]   = i_r0_data[c*DW +: DW];
      w_pix[3+c] = i_r1_data[c*DW +: DW];
      w_pix[6+c] = i_r2_data[c*DW +: DW];
    end
    w_cfg_shift = i_cfg_shift;
    if (int'(i_cfg_shift) > SMAX) begin
      w_cfg_shift = SW'(SMAX);
    end
  end

  // Per-window kernel and shift selection.
  always_comb begin
    for (int k = 0; k < NTAP; k++) begin
      w_coef[k] = r_cust[k];
    end
    w_shift = w_cfg_shift;
    unique case (i_mode)
      MODE_GAUSS: begin
        for (int k = 0; k < NTAP; k++) begin
          w_coef[k] = CIW'($signed(K_GAUSS[k*KW +: KW]));
        end
        w_shift = SW'(S_GAUSS);
      end
      MODE_SHARP: begin
        for (int k = 0; k < NTAP; k++) begin
          w_coef[k] = CIW'($signed(K_SHARP[k*KW +: KW]));
        end
        w_shift = SW'(S_SHARP);
      end
      MODE_EDGE: begin
        for (int k = 0; k < NTAP; k++) begin
          w_coef[k] = CIW'($signed(K_EDGE[k*KW +: KW]));
        end
        w_shift = SW'(S_EDGE);
      end
      MODE_CUSTOM: begin
      end
    endcase
  end

  // Pixels are unsigned, so a zero bit is prepended.
  always_comb begin
    for (int k = 0; k < NTAP; k++) begin
      w_prod[k] = PW'($signed({1'b0, w_pix[k]})) * PW'(w_coef[k]);
    end
  end

  // Adder tree input for stage 2.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NTAP; k++) begin
      w_sum = w_sum + ACCW'(r_s1_prod[k]);
    end
  end

  ps_conv_round_clamp #(
    .ACCW (ACCW),
    .DW   (DW),
    .SW   (SW)
  ) u_rc (
    .i_acc   (r_s2_acc),
    .i_shift (r_s2_shift),
    .o_data  (w_rc_data)
  );

  // Custom kernel store; writes land even while stalled.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 0; k < NTAP; k++) begin
        r_cust[k] <= '0;
      end
      r_cust[4] <= CIW'(1);
    end else if (i_coef_we) begin
      for (int k = 0; k < NTAP; k++) begin
        if (i_coef_addr == 4'(k)) begin
          r_cust[k] <= CIW'(i_coef_data);
        end
      end
    end
  end

  // Rigid 3-stage shift; bubbles travel with the data.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s1_valid <= 1'b0;
      for (int k = 0; k < NTAP; k++) begin
        r_s1_prod[k] <= '0;
      end
      r_s1_shift <= '0;
      r_s2_valid <= 1'b0;
      r_s2_acc   <= '0;
      r_s2_shift <= '0;
      r_o_valid  <= 1'b0;
      r_o_data   <= '0;
    end else if (w_en) begin
      r_s1_valid <= w_acc;
      for (int k = 0; k < NTAP; k++) begin
        r_s1_prod[k] <= w_prod[k];
      end
      r_s1_shift <= w_shift;
      r_s2_valid <= r_s1_valid;
      r_s2_acc   <= w_sum;
      r_s2_shift <= r_s1_shift;
      r_o_valid  <= r_s2_valid;
      if (r_s2_valid) begin
        r_o_data <= w_rc_data;
      end
    end
  end

endmodule

// File: tb/tb_ps_conv3x3.sv
// tb_ps_conv3x3: directed vectors with hand-computed results
// for the 3x3 convolution engine.
module tb_ps_conv3x3;

  localparam int DW = 8;
  localparam int CW = 6;
  localparam int SW = 4;

  logic                 i_clk = 1'b0;
  logic                 i_rstn = 1'b0;
  logic [3*DW-1:0]      i_r0_data = '0;
  logic [3*DW-1:0]      i_r1_data = '0;
  logic [3*DW-1:0]      i_r2_data = '0;
  logic                 i_valid = 1'b0;
  logic                 o_ready;
  logic [1:0]           i_mode = 2'd0;
  logic                 i_coef_we = 1'b0;
  logic [3:0]           i_coef_addr = '0;
  logic signed [CW-1:0] i_coef_data = '0;
  logic [SW-1:0]        i_cfg_shift = '0;
  logic [DW-1:0]        o_data;
  logic                 o_valid;
  logic                 i_ready = 1'b1;

  int n_chk = 0;
  int n_pass = 0;
  int cyc_cnt = 0;
  logic mon_en = 1'b0;
  int q_d[$];
  int q_c[$];
  int k, c, n;
  logic acc;
  int sw_exp [4] = '{40, 160, 90, 0};

  ps_conv3x3 #(
    .DW (DW),
    .CW (CW),
    .SW (SW)
  ) u_dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_r0_data   (i_r0_data),
    .i_r1_data   (i_r1_data),
    .i_r2_data   (i_r2_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_mode      (i_mode),
    .i_coef_we   (i_coef_we),
    .i_coef_addr (i_coef_addr),
    .i_coef_data (i_coef_data),
    .i_cfg_shift (i_cfg_shift),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge i_clk) begin
    if (mon_en && o_valid && i_ready) begin
      q_d.push_back(int'(o_data));
      q_c.push_back(cyc_cnt);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [3*DW-1:0] row(input int l, input int m, input int r);
    return {DW'(r), DW'(m), DW'(l)};
  endfunction

  task automatic set_win(input int t, input int cp, input int nb);
    i_r0_data = row(t, t, t);
    i_r1_data = row(nb, cp, nb);
    i_r2_data = row(t, t, t);
  endtask

  task automatic wr(input int a, input int d);
    i_coef_we = 1'b1;
    i_coef_addr = 4'(a);
    i_coef_data = CW'(d);
    step();
    i_coef_we = 1'b0;
  endtask

  task automatic run1(input string tag, input logic [1:0] m,
                      input int t, input int cp, input int nb,
                      input int s, input int exp);
    int lat;
    i_mode = m;
    i_cfg_shift = SW'(s);
    set_win(t, cp, nb);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    i_coef_we = 1'b0;
    lat = 1;
    while (!o_valid && lat < 8) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_dat"}, int'(o_data), exp);
    step();
  endtask

  initial begin
    #3;
    chk("rst_ovalid", int'(o_valid), 0);
    chk("rst_odata", int'(o_data), 0);
    chk("rst_ordy", int'(o_ready), 1);
    step();
    step();
    i_rstn = 1'b1;
    step();

    run1("gauss200", 2'd0, 200, 200, 200, 0, 200);
    run1("gauss255", 2'd0, 255, 255, 255, 0, 255);
    run1("gauss_rnd", 2'd0, 0, 2, 0, 0, 1);
    run1("gauss_c10", 2'd0, 0, 10, 0, 0, 3);
    run1("sharp_hi", 2'd1, 0, 255, 0, 0, 255);
    run1("sharp_lo", 2'd1, 255, 0, 255, 0, 0);
    run1("sharp_mid", 2'd1, 90, 100, 90, 0, 140);
    run1("edge_flat", 2'd2, 77, 77, 77, 0, 0);
    run1("edge_pk", 2'd2, 10, 20, 10, 0, 80);
    run1("cust_id", 2'd3, 50, 123, 50, 0, 123);

    for (int a = 0; a < 9; a++) wr(a, 1);
    run1("cust_ones", 2'd3, 8, 8, 8, 3, 9);
    i_coef_we = 1'b1;
    i_coef_addr = 4'd4;
    i_coef_data = CW'(2);
    run1("cust_same", 2'd3, 8, 8, 8, 3, 9);
    run1("cust_new", 2'd3, 8, 8, 8, 3, 10);
    wr(12, 0);
    run1("cust_badaddr", 2'd3, 8, 8, 8, 3, 10);

    q_d.delete();
    q_c.delete();
    mon_en = 1'b1;
    i_mode = 2'd0;
    k = 0;
    c = 0;
    while (k < 6 && c < 40) begin
      set_win((k + 1) * 10, (k + 1) * 10, (k + 1) * 10);
      i_valid = 1'b1;
      i_ready = !(c >= 3 && c < 7);
      #1;
      if (c >= 3 && c < 7) begin
        chk("bp_ordy", int'(o_ready), 0);
        chk("bp_hold", int'(o_data), 10);
      end
      acc = o_ready;
      step();
      if (acc) k++;
      c++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    n = 0;
    while (q_d.size() < 6 && n < 20) begin
      step();
      n++;
    end
    step();
    mon_en = 1'b0;
    chk("bp_cnt", q_d.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < q_d.size()) chk("bp_val", q_d[i], (i + 1) * 10);
    end

    q_d.delete();
    q_c.delete();
    mon_en = 1'b1;
    i_mode = 2'd0; set_win(40, 40, 40); i_valid = 1'b1; step();
    i_mode = 2'd2; set_win(10, 30, 10); step();
    i_mode = 2'd0; set_win(90, 90, 90); step();
    i_mode = 2'd2; set_win(5, 5, 5); step();
    i_valid = 1'b0;
    n = 0;
    while (q_d.size() < 4 && n < 20) begin
      step();
      n++;
    end
    mon_en = 1'b0;
    chk("sw_cnt", q_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < q_d.size()) chk("sw_val", q_d[i], sw_exp[i]);
      if (i > 0 && i < q_c.size()) chk("sw_gap", q_c[i] - q_c[i-1], 1);
    end

    i_mode = 2'd0;
    set_win(11, 11, 11); i_valid = 1'b1; step();
    set_win(22, 22, 22); step();
    set_win(33, 33, 33); step();
    i_valid = 1'b0;
    chk("arst_pre_v", int'(o_valid), 1);
    chk("arst_pre_d", int'(o_data), 11);
    #3;
    i_rstn = 1'b0;
    #1;
    chk("arst_ovalid", int'(o_valid), 0);
    chk("arst_ordy", int'(o_ready), 1);
    step();
    step();
    i_rstn = 1'b1;
    q_d.delete();
    q_c.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) step();
    mon_en = 1'b0;
    chk("arst_none", q_d.size(), 0);
    run1("arst_id", 2'd3, 3, 77, 3, 0, 77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
